// File: rtl/fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// fetch_queue_stage: PC generator issuing 1-cycle imem reads into a {pc,instr}
// FIFO that drains to Decode via valid/ready. Revision: 1.0
// ============================================================================
module fetch_queue_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              QDEPTH   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] InstrF,
   output logic [XLEN-1:0] PCF,
   output logic [XLEN-1:0] PCPlus4F
);

   localparam int            PW       = $clog2(QDEPTH);
   localparam int            CW       = $clog2(QDEPTH + 1);
   localparam logic [CW:0]   QDEPTH_W = (CW + 1)'(QDEPTH);

   logic [XLEN-1:0] fetch_pc;
   logic            inflight;
   logic [XLEN-1:0] inflight_pc;
   logic [XLEN-1:0] pc_mem    [QDEPTH];
   logic [XLEN-1:0] instr_mem [QDEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;

   logic            pop;
   logic            push;
   logic            issue;
   logic [CW:0]     occupancy;

   assign instr_valid = !rst && (count != '0);
   assign pop         = instr_valid && instr_ready;
   assign push        = inflight && !PCSrcE;

   // Counting the in-flight request as occupied means a response always finds room.
   assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
   assign issue     = !rst && !PCSrcE && (occupancy < QDEPTH_W);

   assign imem_req  = issue;
   assign imem_addr = fetch_pc;

   assign InstrF   = instr_mem[rd_ptr];
   assign PCF      = pc_mem[rd_ptr];
   assign PCPlus4F = PCF + XLEN'(4);

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else if (PCSrcE) begin
         fetch_pc <= PCTargetE & ~XLEN'(3);
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (issue) begin
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + XLEN'(4);
         end else begin
            inflight <= 1'b0;
         end
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         pc_mem[wr_ptr]    <= inflight_pc;
         instr_mem[wr_ptr] <= imem_rdata;
      end
   end

endmodule
`default_nettype wire

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised fetch stage for the pipelined RV32 core. It replaces the single PC register plus combinational instruction memory with a PC generator that issues requests to a synchronous 1-cycle-latency instruction memory. Returned instructions are buffered in a QDEPTH-entry FIFO of {pc, instr} pairs. The FIFO drains to Decode through a valid/ready handshake. A redirect from Execute (PCSrcE) flushes the buffer and kills the in-flight response.

Parameters:
XLEN, 32, PC and instruction datapath width.
RESET_PC, 32'h0000_0000, fetch address loaded on reset. Must be 4-byte aligned.
QDEPTH, 4, FIFO entries. Power of two, >= 2.

Ports:
clk  in  1  clock, all state updates on posedge.
rst  in  1  synchronous reset, active-high.
PCSrcE  in  1  redirect request from Execute (taken branch/jump).
PCTargetE  in  XLEN  redirect target; bits [1:0] forced to 0 internally.
imem_req  out  1  read request to instruction memory this cycle.
imem_addr  out  XLEN  request address; equals fetch_pc.
imem_rdata  in  XLEN  instruction data, valid in the cycle after imem_req.
instr_valid  out  1  FIFO head is valid.
instr_ready  in  1  Decode accepts head (deasserted = StallD).
InstrF  out  XLEN  head instruction.
PCF  out  XLEN  head PC.
PCPlus4F  out  XLEN  PCF + 4, modulo 2^XLEN.

Behaviour:
- State:
  - fetch_pc register.
  - inflight flag and inflight_pc register for the outstanding request.
  - FIFO: storage, rd/wr pointers, count (0..QDEPTH).
- Reset (rst=1 at posedge):
  - fetch_pc=RESET_PC, inflight=0, count=0, pointers=0.
  - While rst=1: imem_req=0, instr_valid=0, InstrF/PCF/PCPlus4F don't-care; PCSrcE is ignored.
  - Reset mid-operation discards all queued and in-flight instructions.
- pop = instr_valid & instr_ready.
- Issue rule: imem_req = !rst & !PCSrcE & ((count + inflight - pop) < QDEPTH).
  - This guarantees a response never finds the FIFO full, so there is no overflow path.
  - Full throughput (1 instr/cycle) when QDEPTH >= 2.
- On an issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps at 2^XLEN). Otherwise inflight<=0.
- Response: if inflight=1 and no redirect this cycle, push {inflight_pc, imem_rdata} at the posedge ending the cycle after the request.
- Latency: request in cycle n -> data in cycle n+1 -> instr_valid in cycle n+2. First instruction after reset release has PCF=RESET_PC in cycle 2.
- Outputs are driven from FIFO storage (registered); there is no bypass from imem_rdata to InstrF.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo QDEPTH.
- Redirect (PCSrcE=1):
  - No request is issued in that cycle.
  - At the posedge: fetch_pc<=PCTargetE&~3, count<=0, pointers<=0, inflight<=0; the response arriving that cycle is dropped.
  - A pop handshake in the redirect cycle is still considered completed by Decode.
  - instr_valid=0 in the following cycle. First post-redirect instruction appears 2 cycles after the redirect cycle plus 1 (issue cycle), i.e. at cycle r+3.
- Back-to-back redirects: the last one wins; each restarts the sequence.
- Stall (instr_ready=0): the head is held stable (InstrF/PCF unchanged). Fetch continues until count+inflight=QDEPTH, then imem_req=0 until a pop.

Test Plan:
1. Reset release, ready=1, imem returns addr>>2 as data -> instr_valid from cycle 2; PCF=0,4,8,... with one instruction per cycle; InstrF=0,1,2...
2. instr_ready=0 for 10 cycles, QDEPTH=4 -> exactly 4 requests issued (PC 0..12); imem_req=0 afterward; head held at PCF=0. Release -> PCF 0,4,8,12,16 consecutively with no bubble.
3. PCSrcE=1, PCTargetE=32'h0000_0103 while 3 entries are queued and 1 is in flight -> next cycle instr_valid=0, imem_addr=32'h100. Next valid PCF=32'h100 with no stale PCs ever presented.
4. PCSrcE pulsed on two consecutive cycles with targets 0x40 then 0x80 -> only 0x80, 0x84... appear.
5. rst asserted for one cycle mid-stream with queue full -> instr_valid=0 and imem_req=0 during reset; restart from RESET_PC with identical timing to test 1.
6. RESET_PC=32'hFFFF_FFF8 -> PCF sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; PCPlus4F of the last entry = 0000_0004.
